// File: rtl/lex_bus_pkg.sv
// Shared types and helpers for the Lexington SoC bus fabric arbiters.
package lex_bus_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } arb_state_t;

    // Increment with explicit wrap so non-power-of-two counts stay in range.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_picker #(
    parameter int N  = 2,
    parameter int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic          any,
    output logic [SW-1:0] sel,
    output logic [N-1:0]  onehot
);

    int idx;

    always_comb begin
        any    = 1'b0;
        sel    = '0;
        onehot = '0;
        idx    = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx -= N;
            if (!any && req[SW'(idx)]) begin
                any                 = 1'b1;
                sel                 = SW'(idx);
                onehot[SW'(idx)]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter owning one memory-bus slave port; one transaction in flight at a time.
module bus_arbiter
    import lex_bus_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0]            we,
    input  logic [N_REQ*ADDR_W-1:0]     addr,
    input  logic [N_REQ*DATA_W-1:0]     wdata,
    input  logic [N_REQ*(DATA_W/8)-1:0] wmask,
    output logic [N_REQ-1:0]            gnt,
    output logic [N_REQ-1:0]            ack,
    output logic                        err,
    output logic [DATA_W-1:0]           rdata,
    output logic                        m_req,
    output logic                        m_we,
    output logic [ADDR_W-1:0]           m_addr,
    output logic [DATA_W-1:0]           m_wdata,
    output logic [DATA_W/8-1:0]         m_wmask,
    input  logic                        m_ack,
    input  logic [DATA_W-1:0]           m_rdata,
    input  logic                        m_err
);

    localparam int SW = $clog2(N_REQ);
    localparam int MW = DATA_W / 8;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_t state_q, state_d;

    logic [SW-1:0]    ptr_q, sel_q, pick_sel;
    logic             pick_any;
    logic [N_REQ-1:0] pick_oh;
    logic [CW-1:0]    cnt_q;
    logic             timeout_hit;

    logic [N_REQ-1:0][ADDR_W-1:0] addr_a;
    logic [N_REQ-1:0][DATA_W-1:0] wdata_a;
    logic [N_REQ-1:0][MW-1:0]     wmask_a;

    assign addr_a  = addr;
    assign wdata_a = wdata;
    assign wmask_a = wmask;

    rr_picker #(.N(N_REQ), .SW(SW)) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .any    (pick_any),
        .sel    (pick_sel),
        .onehot (pick_oh)
    );

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_any) state_d = BUSY;
            BUSY:    if (m_ack || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant is combinational so a master sees acceptance in its request cycle.
    always_comb begin
        gnt = '0;
        ack = '0;
        if (state_q == IDLE && !rst) gnt = pick_oh;
        if (state_q == RESP) ack[sel_q] = 1'b1;
    end

    assign m_req = (state_q == BUSY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_wmask <= '0;
            rdata   <= '0;
            err     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        sel_q   <= pick_sel;
                        m_we    <= we[pick_sel];
                        m_addr  <= addr_a[pick_sel];
                        m_wdata <= wdata_a[pick_sel];
                        m_wmask <= wmask_a[pick_sel];
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q + 1'b1;
                    // A real completion beats a timeout landing in the same cycle.
                    if (m_ack) begin
                        rdata <= m_rdata;
                        err   <= m_err;
                    end else if (timeout_hit) begin
                        rdata <= '0;
                        err   <= 1'b1;
                    end
                end
                RESP: begin
                    ptr_q <= SW'(wrap_inc(32'(sel_q), N_REQ));
                    cnt_q <= '0;
                    rdata <= '0;
                    err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter sharing one memory-bus slave port between N_REQ masters (e.g. instruction fetch, load/store, debug) in the Lexington SoC.
- Captures one request at a time, holds it on the downstream port until acknowledged or timed out, then returns the response to the owning master.
- Sits between core-side bus masters and the memory/peripheral interconnect.

Parameters:
- N_REQ, 2, number of requesting masters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- TIMEOUT, 64, BUSY cycles without m_ack before an error response is returned; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-master request, level; held until gnt.
- we  in  N_REQ  per-master write enable.
- addr  in  N_REQ*ADDR_W  per-master address, packed with master i at bits [i*ADDR_W +: ADDR_W].
- wdata  in  N_REQ*DATA_W  per-master write data, packed the same way.
- wmask  in  N_REQ*(DATA_W/8)  per-master byte strobes, packed the same way.
- gnt  out  N_REQ  one-hot pulse: request accepted this cycle.
- ack  out  N_REQ  one-hot pulse: transaction complete.
- err  out  1  valid with ack; bus error or timeout.
- rdata  out  DATA_W  read data, valid with ack; shared by all masters.
- m_req  out  1  downstream request, level.
- m_we  out  1  downstream write enable.
- m_addr  out  ADDR_W  downstream address.
- m_wdata  out  DATA_W  downstream write data.
- m_wmask  out  DATA_W/8  downstream byte strobes.
- m_ack  in  1  downstream completion pulse.
- m_rdata  in  DATA_W  downstream read data, valid with m_ack.
- m_err  in  1  downstream error, valid with m_ack.

Behaviour:
- Reset (async, asserted):
  - state=IDLE, ptr=0, sel=0, timeout counter=0.
  - All outputs 0: gnt, ack, err, rdata, m_req, m_we, m_addr, m_wdata, m_wmask.
  - Assertion mid-transaction drops m_req immediately; no ack is ever issued for the aborted transaction.
- FSM: IDLE -> BUSY -> RESP -> IDLE.
- IDLE:
  - If any req bit is set, pick the first set bit scanning ptr, ptr+1, ..., wrapping mod N_REQ.
  - gnt[sel] is combinational in the same cycle.
  - On the clock edge: latch we/addr/wdata/wmask of sel into output registers, store sel, go to BUSY.
  - No req set: stay in IDLE, all gnt=0.
- BUSY:
  - m_req=1; m_* fields are registered and stable until exit.
  - Timeout counter increments every cycle.
  - m_ack=1: register m_rdata into rdata and m_err into err, drop m_req next cycle, go to RESP.
  - Else, if TIMEOUT!=0 and counter==TIMEOUT-1: go to RESP with err=1 and rdata=0.
  - If m_ack and timeout fire in the same cycle, m_ack wins and its data and error are used.
- RESP (one cycle):
  - ack[sel]=1; err and rdata are valid.
  - ptr <= (sel+1) mod N_REQ, with explicit wrap for non-power-of-two N_REQ.
  - Counter cleared; go to IDLE.
  - err and rdata return to 0 in IDLE.
- Timing:
  - Grant at cycle 0, m_req at cycles 1..k, m_ack at cycle k, ack at cycle k+1.
  - Minimum turnaround is 3 cycles per transaction (m_ack at cycle 1).
  - Next gnt no earlier than cycle k+2.
- Ignored inputs:
  - m_ack outside BUSY is ignored.
  - req from the owning master after gnt is ignored until IDLE, when it arbitrates normally at lowest priority.
- Masters may drop req before gnt; arbitration samples only the current cycle.
- Fairness: with all masters requesting continuously, grants rotate 0,1,...,N_REQ-1,0.

Decomposition:
- Package lex_bus_pkg:
  - arb_state_t enum (IDLE, BUSY, RESP).
  - Default ADDR_W/DATA_W constants.
  - Function wrap_inc(idx, n).
- Sub-module rr_picker (combinational):
  - Inputs: req vector, ptr.
  - Outputs: any, sel index, one-hot.
  - Reusable by interrupt and DMA arbitration.

Test Plan:
- Single master: reset, then req[0]=1, we=0, addr=0x100; slave acks 2 cycles after m_req with m_rdata=0xDEADBEEF.
  - Required: gnt[0] at cycle 0, m_addr=0x100 at cycles 1–2, ack[0] at cycle 3 with rdata=0xDEADBEEF, err=0.
- Contention, N_REQ=3, all req held, zero-wait slave:
  - Required: grant order 0,1,2,0,1,2, exactly one gnt bit high at a time, ptr wraps from 2 to 0.
- Write path: req[1] write, addr=0x2000_0004, wdata=0x1234_5678, wmask=0b0011.
  - Required: m_we=1 with the same values held stable on the m_* port every cycle until m_ack.
- Timeout with TIMEOUT=8: slave never acks.
  - Required: m_req high for exactly 8 cycles, then ack[sel]=1 with err=1, rdata=0, and the next request is served normally.
- Error and collision:
  - m_ack=1 with m_err=1 → ack with err=1.
  - m_ack on the final timeout cycle → err equals m_err and rdata equals m_rdata.
- Reset mid-BUSY: assert rst between clock edges.
  - Required: m_req falls asynchronously, no ack is issued, and after release the first grant goes to master 0.
